// File: rtl/mac_sequencer_if.sv
// ---------------------------------------------------------------------------
// Module   : mac_sequencer_if
// Purpose  : Control, MAC and result-handshake signals of one neuron sequencer.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface mac_sequencer_if #(
  parameter int N  = 8,
  parameter int CW = 8
);
  logic                   start;
  logic [CW-1:0]          count;
  logic [N-1:0]           bias_in;
  logic                   rd_en;
  logic [CW-1:0]          rd_addr;
  logic                   mac_clk_en;
  logic                   mac_ctrl_rst;
  logic                   mac_use_bias;
  logic [N-1:0]           mac_bias;
  logic signed [3*N-4:0]  mac_sum;
  logic [N-1:0]           out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;

  modport master (
    input  start, count, bias_in, mac_sum, out_ready,
    output rd_en, rd_addr, mac_clk_en, mac_ctrl_rst, mac_use_bias, mac_bias,
           out_data, out_valid, busy
  );

  modport slave (
    output start, count, bias_in, mac_sum, out_ready,
    input  rd_en, rd_addr, mac_clk_en, mac_ctrl_rst, mac_use_bias, mac_bias,
           out_data, out_valid, busy
  );
endinterface

`default_nettype wire

// File: rtl/mac_sequencer.sv
// ---------------------------------------------------------------------------
// Module   : mac_sequencer
// Purpose  : Sequences K operand reads into a MAC, adds bias, applies
//            shift/ReLU/saturation and hands one activation downstream.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mac_sequencer #(
  parameter int N     = 8,
  parameter int CW    = 8,
  parameter int SHIFT = 0
) (
  input  wire logic         clk,
  input  wire logic         rst,
  mac_sequencer_if.master   bus
);

  localparam int SW = 3*N-3;
  localparam logic signed [SW-1:0] c_max = SW'((1 << (N-1)) - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACC   = 3'd2,
    S_BIAS  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         r_addr;
  logic [N-1:0]          r_bias;
  logic [N-1:0]          r_out;
  logic                  r_rd_d;
  logic                  w_rd_en;
  logic signed [SW-1:0]  w_shifted;
  logic [N-1:0]          w_act;

  // r_addr holds the next address to issue; ACC ends once it reaches K,
  // which is the cycle the product for K-1 arrives at the MAC.
  always_comb begin
    w_next  = r_state;
    w_rd_en = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_CLEAR;
      S_CLEAR: begin
        w_rd_en = (r_count != '0);
        w_next  = (r_count != '0) ? S_ACC : S_BIAS;
      end
      S_ACC: begin
        w_rd_en = (r_addr != r_count);
        if (r_addr == r_count) w_next = S_BIAS;
      end
      S_BIAS:  w_next = S_OUT;
      S_OUT:   if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_shifted = $signed(bus.mac_sum) >>> SHIFT;
    if (w_shifted < 0)
      w_act = '0;
    else if (w_shifted > c_max)
      w_act = c_max[N-1:0];
    else
      w_act = w_shifted[N-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_addr  <= '0;
      r_bias  <= '0;
      r_out   <= '0;
      r_rd_d  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rd_d  <= w_rd_en;
      if (r_state == S_IDLE && bus.start) begin
        r_count <= bus.count;
        r_bias  <= bus.bias_in;
        r_addr  <= '0;
      end else if (w_rd_en) begin
        r_addr  <= r_addr + 1'b1;
      end
      if (r_state == S_BIAS) r_out <= w_act;
    end
  end

  assign bus.rd_en        = w_rd_en;
  assign bus.rd_addr      = w_rd_en ? r_addr : '0;
  assign bus.mac_clk_en   = r_rd_d | (r_state == S_BIAS);
  assign bus.mac_ctrl_rst = (r_state == S_CLEAR);
  assign bus.mac_use_bias = (r_state == S_BIAS);
  assign bus.mac_bias     = r_bias;
  assign bus.out_data     = r_out;
  assign bus.out_valid    = (r_state == S_OUT);
  assign bus.busy         = (r_state != S_IDLE);

endmodule

`default_nettype wire
